// File: rtl/dmem_access_ctrl_if.sv
// One requester port of the data-memory access controller: request fields and the
// single-cycle completion response.
interface dmem_access_ctrl_if #(
    parameter int AW = 13,
    parameter int DW = 32
);
    // Handshake: a request transfers on a rising clk edge where req_valid && req_ready.
    // The master holds req_valid and every request field stable until then. The response
    // is a one-cycle rsp_valid pulse with rsp_err/rdata alongside; it cannot be stalled.
    logic          req_valid;
    logic          req_ready;
    logic          we;
    logic [1:0]    size;
    logic          is_unsigned;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          rsp_valid;
    logic          rsp_err;
    logic [DW-1:0] rdata;

    modport master (
        output req_valid, we, size, is_unsigned, addr, wdata,
        input  req_ready, rsp_valid, rsp_err, rdata
    );

    modport slave (
        input  req_valid, we, size, is_unsigned, addr, wdata,
        output req_ready, rsp_valid, rsp_err, rdata
    );
endinterface

// File: rtl/dmem_access_ctrl.sv
// Shares a word-wide data memory between two requesters with round-robin arbitration,
// sub-word loads with extension, and sub-word stores by read-modify-write.
module dmem_access_ctrl #(
    parameter int DATA_WIDTH    = 32,
    parameter int DMEM_SZ_IN_KB = 1,
    parameter int ADDR_WIDTH    = $clog2(DMEM_SZ_IN_KB * 1024 * 8)
) (
    input  logic                  clk,
    input  logic                  arst_n,
    dmem_access_ctrl_if.slave     p0,
    dmem_access_ctrl_if.slave     p1,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [1:0]            dbg_state
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_WRITE  = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    logic [1:0]            state;
    logic                  last_grant;
    logic                  grant;
    logic                  accept;
    logic                  port_q;
    logic                  we_q;
    logic                  uns_q;
    logic                  err_q;
    logic [1:0]            size_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  addr_err;
    logic [4:0]            lane_lsb;
    logic [7:0]            ld_byte;
    logic [15:0]           ld_half;
    logic [DATA_WIDTH-1:0] ld_ext;
    logic [DATA_WIDTH-1:0] merged;
    logic                  in_mem_phase;

    // Contended grant goes to the port that did not win last time.
    always_comb begin
        accept = (state == S_IDLE) && (p0.req_valid || p1.req_valid);
        grant  = (p0.req_valid && p1.req_valid) ? ~last_grant : p1.req_valid;
    end

    assign p0.req_ready = (state == S_IDLE) && p0.req_valid && !grant;
    assign p1.req_ready = (state == S_IDLE) && p1.req_valid && grant;

    always_comb begin
        addr_err = (size_q == 2'b11)
                || ((size_q == SZ_HALF) && addr_q[0])
                || ((size_q == SZ_WORD) && (addr_q[1:0] != 2'b00));
        lane_lsb = {addr_q[1:0], 3'b000};
        ld_byte  = mem_rdata[lane_lsb +: 8];
        ld_half  = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (size_q)
            SZ_BYTE: ld_ext = {{24{~uns_q & ld_byte[7]}}, ld_byte};
            SZ_HALF: ld_ext = {{16{~uns_q & ld_half[15]}}, ld_half};
            default: ld_ext = mem_rdata;
        endcase
        merged = mem_rdata;
        if (size_q == SZ_BYTE) begin
            merged[lane_lsb +: 8] = wdata_q[7:0];
        end else if (addr_q[1]) begin
            merged[31:16] = wdata_q[15:0];
        end else begin
            merged[15:0] = wdata_q[15:0];
        end
    end

    always_comb begin
        in_mem_phase = (state == S_ACCESS) || (state == S_WRITE);
        mem_we       = ((state == S_ACCESS) && we_q && !addr_err && (size_q == SZ_WORD))
                    || (state == S_WRITE);
        mem_addr     = in_mem_phase ? {addr_q[ADDR_WIDTH-1:2], 2'b00} : '0;
        if (state == S_WRITE) begin
            mem_wdata = data_q;
        end else if (mem_we) begin
            mem_wdata = wdata_q;
        end else begin
            mem_wdata = '0;
        end
    end

    // data_q holds the load result or, between ACCESS and WRITE, the merged store word;
    // it is zero in DONE for stores and errors so rdata reads 0 for them.
    always_comb begin
        p0.rsp_valid = (state == S_DONE) && !port_q;
        p1.rsp_valid = (state == S_DONE) && port_q;
        p0.rsp_err   = p0.rsp_valid && err_q;
        p1.rsp_err   = p1.rsp_valid && err_q;
        p0.rdata     = p0.rsp_valid ? data_q : '0;
        p1.rdata     = p1.rsp_valid ? data_q : '0;
        dbg_state    = state;
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state      <= S_IDLE;
            last_grant <= 1'b1;
            port_q     <= 1'b0;
            we_q       <= 1'b0;
            uns_q      <= 1'b0;
            err_q      <= 1'b0;
            size_q     <= 2'b00;
            addr_q     <= '0;
            wdata_q    <= '0;
            data_q     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        port_q     <= grant;
                        last_grant <= grant;
                        we_q       <= grant ? p1.we          : p0.we;
                        size_q     <= grant ? p1.size        : p0.size;
                        uns_q      <= grant ? p1.is_unsigned : p0.is_unsigned;
                        addr_q     <= grant ? p1.addr        : p0.addr;
                        wdata_q    <= grant ? p1.wdata       : p0.wdata;
                        state      <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    err_q <= addr_err;
                    if (addr_err) begin
                        data_q <= '0;
                        state  <= S_DONE;
                    end else if (!we_q) begin
                        data_q <= ld_ext;
                        state  <= S_DONE;
                    end else if (size_q == SZ_WORD) begin
                        data_q <= '0;
                        state  <= S_DONE;
                    end else begin
                        data_q <= merged;
                        state  <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    data_q <= '0;
                    state  <= S_DONE;
                end
                default: begin
                    err_q <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Bench for dmem_access_ctrl: directed cases pinned to literal values, then random traffic
// on both ports checked every cycle against a transaction-level model.
module tb_dmem_access_ctrl;
  localparam int AW = 13;
  localparam int DW = 32;

  typedef struct {
    int          due;
    bit          port;
    bit          err;
    logic [31:0] rdata;
    bit          wr;
    int          idx;
    logic [31:0] wval;
  } exp_t;

  logic          clk;
  logic          arst_n;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic [1:0]    dbg_state;

  dmem_access_ctrl_if #(.AW(AW), .DW(DW)) p0_if ();
  dmem_access_ctrl_if #(.AW(AW), .DW(DW)) p1_if ();

  dmem_access_ctrl #(.DATA_WIDTH(DW), .DMEM_SZ_IN_KB(1)) dut (
    .clk       (clk),
    .arst_n    (arst_n),
    .p0        (p0_if),
    .p1        (p1_if),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // environment memory, with a backdoor port used only while the controller is idle
  logic [31:0] mem_arr [0:2047];
  logic        bd_we;
  logic [10:0] bd_idx;
  logic [31:0] bd_val;
  int          we_cnt = 0;

  assign mem_rdata = mem_arr[mem_addr[12:2]];

  always @(posedge clk) begin
    if (mem_we) begin
      mem_arr[mem_addr[12:2]] <= mem_wdata;
      we_cnt <= we_cnt + 1;
    end
    if (bd_we) mem_arr[bd_idx] <= bd_val;
  end

  // scoreboard state
  int          vec_cnt = 0;
  int          miss_cnt = 0;
  int          cyc = 0;
  int          busy_due = -1;
  bit          lg_m = 1'b1;
  logic [31:0] ref_mem [0:2047];
  exp_t        exp_q[$];
  bit          grant_log[$];
  int          rsp_cnt0 = 0;
  int          rsp_cnt1 = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // transaction-level reference: computes the whole outcome of one accepted request
  function automatic exp_t model(input bit p);
    logic        we, un;
    logic [1:0]  sz;
    logic [12:0] a;
    logic [31:0] d, w, v, mask;
    int          idx, off, lat;
    exp_t        e;
    we  = p ? p1_if.we          : p0_if.we;
    sz  = p ? p1_if.size        : p0_if.size;
    un  = p ? p1_if.is_unsigned : p0_if.is_unsigned;
    a   = p ? p1_if.addr        : p0_if.addr;
    d   = p ? p1_if.wdata       : p0_if.wdata;
    idx = int'(a[12:2]);
    off = int'(a[1:0]);
    e   = '{due: 0, port: p, err: 0, rdata: 32'h0, wr: 0, idx: 0, wval: 32'h0};
    lat = 2;
    e.err = (sz == 2'd3) || (sz == 2'd1 && (off % 2) != 0) || (sz == 2'd2 && off != 0);
    if (!e.err) begin
      w = ref_mem[idx];
      if (!we) begin
        v = w >> (8 * off);
        if (sz == 2'd0) begin
          v = v & 32'h0000_00FF;
          if (!un && v[7]) v = v | 32'hFFFF_FF00;
        end else if (sz == 2'd1) begin
          v = v & 32'h0000_FFFF;
          if (!un && v[15]) v = v | 32'hFFFF_0000;
        end
        e.rdata = v;
      end else begin
        e.wr  = 1'b1;
        e.idx = idx;
        if (sz == 2'd2) begin
          e.wval = d;
        end else begin
          mask   = ((sz == 2'd0) ? 32'h0000_00FF : 32'h0000_FFFF) << (8 * off);
          e.wval = (w & ~mask) | ((d << (8 * off)) & mask);
          lat    = 3;
        end
      end
    end
    e.due = cyc + lat;
    return e;
  endfunction

  // compare process: every cycle, away from the active edge
  logic v0, v1, r0, r1, ev0, ev1, ee0, ee1, g;
  logic [31:0] ed0, ed1;
  exp_t e_acc, e_rsp;

  always @(negedge clk) begin
    cyc++;
    if (bd_we) ref_mem[bd_idx] = bd_val;
    if (!arst_n) begin
      exp_q.delete();
      busy_due = -1;
      lg_m     = 1'b1;
      chk("rst_state", {30'd0, dbg_state}, 32'd0);
      chk("rst_ctrl", {26'd0, p0_if.rsp_valid, p1_if.rsp_valid, p0_if.rsp_err,
                       p1_if.rsp_err, mem_we, |mem_addr}, 32'd0);
      chk("rst_data", p0_if.rdata | p1_if.rdata | mem_wdata, 32'd0);
    end else begin
      v0 = p0_if.req_valid; v1 = p1_if.req_valid;
      r0 = p0_if.req_ready; r1 = p1_if.req_ready;
      if (cyc > busy_due && (v0 || v1)) begin
        g = (v0 && v1) ? ~lg_m : v1;
        chk("grant", {30'd0, r1, r0}, g ? 32'd2 : 32'd1);
        e_acc = model(g);
        exp_q.push_back(e_acc);
        busy_due = e_acc.due;
        lg_m     = g;
      end else begin
        chk("ready_busy", {30'd0, r1, r0}, 32'd0);
      end
      if (v0 && r0) grant_log.push_back(1'b0);
      if (v1 && r1) grant_log.push_back(1'b1);
      ev0 = 0; ev1 = 0; ee0 = 0; ee1 = 0; ed0 = 0; ed1 = 0;
      if (exp_q.size() != 0 && exp_q[0].due == cyc) begin
        e_rsp = exp_q.pop_front();
        if (e_rsp.wr) ref_mem[e_rsp.idx] = e_rsp.wval;
        if (e_rsp.port) begin ev1 = 1; ee1 = e_rsp.err; ed1 = e_rsp.rdata; end
        else begin ev0 = 1; ee0 = e_rsp.err; ed0 = e_rsp.rdata; end
      end
      chk("rsp_valid", {30'd0, p1_if.rsp_valid, p0_if.rsp_valid}, {30'd0, ev1, ev0});
      chk("rsp_err", {30'd0, p1_if.rsp_err, p0_if.rsp_err}, {30'd0, ee1, ee0});
      chk("rdata0", p0_if.rdata, ed0);
      chk("rdata1", p1_if.rdata, ed1);
      chk("we_with_rsp", {31'd0, mem_we & (p0_if.rsp_valid | p1_if.rsp_valid)}, 32'd0);
      chk("addr_align", {30'd0, mem_addr[1:0]}, 32'd0);
      if (p0_if.rsp_valid) rsp_cnt0++;
      if (p1_if.rsp_valid) rsp_cnt1++;
    end
  end

  // driver tasks
  task automatic set_port(input bit p, input logic v, input logic we, input logic [1:0] sz,
                          input logic un, input logic [12:0] a, input logic [31:0] d);
    if (p) begin
      p1_if.req_valid = v; p1_if.we = we; p1_if.size = sz;
      p1_if.is_unsigned = un; p1_if.addr = a; p1_if.wdata = d;
    end else begin
      p0_if.req_valid = v; p0_if.we = we; p0_if.size = sz;
      p0_if.is_unsigned = un; p0_if.addr = a; p0_if.wdata = d;
    end
  endtask

  task automatic send(input bit p, input logic we, input logic [1:0] sz, input logic un,
                      input logic [12:0] a, input logic [31:0] d);
    bit done;
    done = 0;
    set_port(p, 1'b1, we, sz, un, a, d);
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (p ? p1_if.req_ready : p0_if.req_ready) done = 1;
    end
    if (!done) begin
      vec_cnt++; miss_cnt++;
      $display("FAIL accept_timeout port=%0d got no ready want ready within 100 cycles", p);
    end
    @(posedge clk); #1;
    set_port(p, 1'b0, we, sz, un, a, d);
  endtask

  task automatic wait_rsp(input bit p, output logic err, output logic [31:0] data, output int lat);
    lat = 0; err = 0; data = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (p ? p1_if.rsp_valid : p0_if.rsp_valid) begin
        lat  = i;
        err  = p ? p1_if.rsp_err : p0_if.rsp_err;
        data = p ? p1_if.rdata : p0_if.rdata;
        break;
      end
    end
    if (lat == 0) begin
      vec_cnt++; miss_cnt++;
      $display("FAIL rsp_timeout port=%0d got no rsp_valid want one within 10 cycles", p);
    end
  endtask

  task automatic poke(input int idx, input logic [31:0] val);
    @(posedge clk); #1;
    bd_we = 1'b1; bd_idx = 11'(idx); bd_val = val;
    @(posedge clk); #1;
    bd_we = 1'b0;
  endtask

  task automatic rand_port(input bit p, input int n);
    logic [1:0]  sz;
    logic [12:0] a;
    int          r;
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      r  = $urandom_range(0, 9);
      sz = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
      a  = 13'($urandom_range(0, 63));
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'd1) a[0] = 1'b0;
        if (sz == 2'd2) a[1:0] = 2'b00;
      end
      send(p, 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog got no finish want finish before 300us");
    $fatal(1, "watchdog");
  end

  logic        t_err;
  logic [31:0] t_data;
  int          t_lat;
  int          w0, c0, c1;
  logic [3:0]  order;

  initial begin
    arst_n = 1'b0;
    bd_we = 1'b0; bd_idx = '0; bd_val = '0;
    set_port(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 13'd0, 32'd0);
    set_port(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 13'd0, 32'd0);
    repeat (3) @(negedge clk);
    #1 arst_n = 1'b1;
    for (int i = 0; i < 16; i++) poke(i, $urandom);

    // both ports valid back to back: strict alternation starting at p0
    @(posedge clk); #1;
    grant_log.delete();
    c0 = rsp_cnt0; c1 = rsp_cnt1;
    fork
      begin send(1'b0, 1'b0, 2'd2, 1'b0, 13'h00, 32'd0); send(1'b0, 1'b0, 2'd2, 1'b0, 13'h04, 32'd0); end
      begin send(1'b1, 1'b0, 2'd2, 1'b0, 13'h08, 32'd0); send(1'b1, 1'b0, 2'd2, 1'b0, 13'h0C, 32'd0); end
    join
    repeat (6) @(negedge clk);
    chk("rr_count", grant_log.size(), 32'd4);
    order = 4'hF;
    if (grant_log.size() >= 4) order = {grant_log[0], grant_log[1], grant_log[2], grant_log[3]};
    chk("rr_order", {28'd0, order}, 32'b0101);
    chk("rr_rsp0", rsp_cnt0 - c0, 32'd2);
    chk("rr_rsp1", rsp_cnt1 - c1, 32'd2);

    // word load
    poke(4, 32'hDEAD_BEEF);
    send(1'b0, 1'b0, 2'd2, 1'b0, 13'h10, 32'd0);
    wait_rsp(1'b0, t_err, t_data, t_lat);
    chk("ldw_data", t_data, 32'hDEAD_BEEF);
    chk("ldw_err", {31'd0, t_err}, 32'd0);
    chk("ldw_lat", t_lat, 32'd2);

    // byte load, signed then unsigned
    poke(4, 32'h80FF_0000);
    send(1'b0, 1'b0, 2'd0, 1'b0, 13'h13, 32'd0);
    wait_rsp(1'b0, t_err, t_data, t_lat);
    chk("ldb_signed", t_data, 32'hFFFF_FF80);
    send(1'b0, 1'b0, 2'd0, 1'b1, 13'h13, 32'd0);
    wait_rsp(1'b0, t_err, t_data, t_lat);
    chk("ldb_unsigned", t_data, 32'h0000_0080);

    // byte store by read-modify-write
    poke(8, 32'h1122_3344);
    send(1'b0, 1'b1, 2'd0, 1'b0, 13'h21, 32'h0000_00AB);
    wait_rsp(1'b0, t_err, t_data, t_lat);
    chk("stb_lat", t_lat, 32'd3);
    chk("stb_rdata", t_data, 32'd0);
    chk("stb_mem", mem_arr[8], 32'h1122_AB44);

    // misaligned word store and illegal size
    w0 = we_cnt;
    send(1'b0, 1'b1, 2'd2, 1'b0, 13'h22, 32'hCAFE_F00D);
    wait_rsp(1'b0, t_err, t_data, t_lat);
    chk("misal_err", {31'd0, t_err}, 32'd1);
    chk("misal_lat", t_lat, 32'd2);
    send(1'b1, 1'b0, 2'd3, 1'b0, 13'h24, 32'd0);
    wait_rsp(1'b1, t_err, t_data, t_lat);
    chk("illsz_err", {31'd0, t_err}, 32'd1);
    chk("illsz_rdata", t_data, 32'd0);
    chk("err_no_we", we_cnt - w0, 32'd0);
    chk("err_mem", mem_arr[8], 32'h1122_AB44);

    // reset during the write phase of a half store
    w0 = we_cnt;
    send(1'b0, 1'b1, 2'd1, 1'b0, 13'h20, 32'h0000_5566);
    @(negedge clk);
    @(negedge clk);
    chk("hst_write_we", {31'd0, mem_we}, 32'd1);
    #1 arst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("abort_idle", {30'd0, dbg_state}, 32'd0);
    #1 arst_n = 1'b1;
    chk("abort_mem", mem_arr[8], 32'h1122_3344 & 32'h0 | 32'h1122_AB44);
    chk("abort_no_we", we_cnt - w0, 32'd0);
    @(posedge clk); #1;
    grant_log.delete();
    fork
      send(1'b0, 1'b0, 2'd2, 1'b0, 13'h00, 32'd0);
      send(1'b1, 1'b0, 2'd2, 1'b0, 13'h04, 32'd0);
    join
    chk("abort_first_grant", grant_log.size() > 0 ? {31'd0, grant_log[0]} : 32'hFFFF_FFFF, 32'd0);
    repeat (6) @(negedge clk);

    // random traffic on both ports
    @(posedge clk); #1;
    fork
      rand_port(1'b0, 60);
      rand_port(1'b1, 60);
    join
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    chk("drain", exp_q.size(), 32'd0);
    for (int i = 0; i < 16; i++) chk("final_mem", mem_arr[i], ref_mem[i]);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end
endmodule
